// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built from a bank of toggle cells.
// Every next-state value, including load and wrap, is expressed as a T vector.
module tff_updown_counter #(
   parameter int     WIDTH   = 4,
   parameter longint MODULUS = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_clr_ovf,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_qb,
   output logic             o_tc,
   output logic             o_wrap,
   output logic             o_ovf
);

   localparam logic [WIDTH-1:0] L_TOP = WIDTH'(MODULUS - 1);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("tff_updown_counter: WIDTH out of range");
   end
   if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_mod
      $error("tff_updown_counter: MODULUS out of range");
   end

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_qb;
   logic [WIDTH-1:0] w_inc_t;
   logic [WIDTH-1:0] w_dec_t;
   logic [WIDTH-1:0] w_ld_val;
   logic [WIDTH-1:0] w_t;
   logic             w_at_top;
   logic             w_at_zero;
   logic             w_wrap_ev;

   assign w_qb      = ~r_q;
   assign w_at_top  = (r_q == L_TOP);
   assign w_at_zero = (r_q == '0);
   assign w_ld_val  = (i_din > L_TOP) ? L_TOP : i_din;

   // Ripple-carry toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down)
   assign w_inc_t[0] = 1'b1;
   assign w_dec_t[0] = 1'b1;
   for (genvar i = 1; i < WIDTH; i++) begin : g_tog
      assign w_inc_t[i] = &r_q[i-1:0];
      assign w_dec_t[i] = &w_qb[i-1:0];
   end

   always_comb begin
      w_t       = '0;
      w_wrap_ev = 1'b0;
      if (i_load) begin
         w_t = r_q ^ w_ld_val;
      end else if (i_en) begin
         if (i_up) begin
            if (w_at_top) begin
               w_t       = r_q;
               w_wrap_ev = 1'b1;
            end else begin
               w_t = w_inc_t;
            end
         end else begin
            if (w_at_zero) begin
               w_t       = r_q ^ L_TOP;
               w_wrap_ev = 1'b1;
            end else begin
               w_t = w_dec_t;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q    <= '0;
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_q    <= r_q ^ w_t;
         r_wrap <= w_wrap_ev;
         r_ovf  <= w_wrap_ev | (r_ovf & ~i_clr_ovf);
      end
   end

   assign o_q    = r_q;
   assign o_qb   = w_qb;
   assign o_tc   = i_en & (i_up ? w_at_top : w_at_zero);
   assign o_wrap = r_wrap;
   assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Directed bench for tff_updown_counter: MOD-10, MOD-16 and 1-bit T flip-flop
// instances checked against hand-computed sequences.
module tb_tff_updown_counter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       en10, up10, ld10, clr10;
   logic [3:0] din10, q10, qb10;
   logic       tc10, wr10, ovf10;

   logic       en16, up16, ld16, clr16;
   logic [3:0] din16, q16, qb16;
   logic       tc16, wr16, ovf16;

   logic       en2, up2, ld2, clr2;
   logic [0:0] din2, q2, qb2;
   logic       tc2, wr2, ovf2;

   int n_chk  = 0;
   int n_fail = 0;

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_d10 (
      .i_clk(clk), .i_rst(rst), .i_en(en10), .i_up(up10),
      .i_load(ld10), .i_din(din10), .i_clr_ovf(clr10),
      .o_q(q10), .o_qb(qb10), .o_tc(tc10), .o_wrap(wr10), .o_ovf(ovf10));

   tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u_d16 (
      .i_clk(clk), .i_rst(rst), .i_en(en16), .i_up(up16),
      .i_load(ld16), .i_din(din16), .i_clr_ovf(clr16),
      .o_q(q16), .o_qb(qb16), .o_tc(tc16), .o_wrap(wr16), .o_ovf(ovf16));

   tff_updown_counter #(.WIDTH(1), .MODULUS(2)) u_d2 (
      .i_clk(clk), .i_rst(rst), .i_en(en2), .i_up(up2),
      .i_load(ld2), .i_din(din2), .i_clr_ovf(clr2),
      .o_q(q2), .o_qb(qb2), .o_tc(tc2), .o_wrap(wr2), .o_ovf(ovf2));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk10(input string tag, input logic [3:0] eq,
                        input logic ew, input logic eo, input logic et);
      logic [3:0] eqb;
      eqb = ~eq;
      chk({tag, ".q"},    32'(q10),  32'(eq));
      chk({tag, ".qb"},   32'(qb10), 32'(eqb));
      chk({tag, ".wrap"}, 32'(wr10), 32'(ew));
      chk({tag, ".ovf"},  32'(ovf10), 32'(eo));
      chk({tag, ".tc"},   32'(tc10), 32'(et));
   endtask

   initial begin
      logic [3:0] dn_q [4];
      logic       dn_w [4];
      logic [3:0] e;
      dn_q = '{4'd1, 4'd0, 4'd9, 4'd8};
      dn_w = '{1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1;
      {en10, up10, ld10, clr10, din10} = '0;
      {en16, up16, ld16, clr16, din16} = '0;
      {en2, up2, ld2, clr2, din2}      = '0;
      tick;
      chk10("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      chk("reset.q16", 32'(q16), 32'd0);
      chk("reset.qb2", 32'(qb2), 32'd1);

      // up count 1..9,0,1,2
      rst = 1'b0; en10 = 1'b1; up10 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick;
         e = 4'(k % 10);
         chk10($sformatf("up%0d", k), e, k == 10, k >= 10, e == 4'd9);
      end

      // down count across zero
      ld10 = 1'b1; din10 = 4'd2; en10 = 1'b0;
      tick;
      chk10("ld2", 4'd2, 1'b0, 1'b1, 1'b0);
      ld10 = 1'b0; en10 = 1'b1; up10 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick;
         chk10($sformatf("dn%0d", k), dn_q[k], dn_w[k], 1'b1,
               dn_q[k] == 4'd0);
      end

      // saturating load, then load beats a pending wrap at q=9
      ld10 = 1'b1; din10 = 4'd13; up10 = 1'b1;
      tick;
      chk10("ldsat", 4'd9, 1'b0, 1'b1, 1'b1);
      din10 = 4'd7;
      tick;
      chk10("ld7", 4'd7, 1'b0, 1'b1, 1'b0);
      ld10 = 1'b0; en10 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk10($sformatf("hold%0d", k), 4'd7, 1'b0, 1'b1, 1'b0);
      end

      // ovf clear, then set wins over clear on wrapping edge
      clr10 = 1'b1;
      tick;
      chk10("clr", 4'd7, 1'b0, 1'b0, 1'b0);
      clr10 = 1'b0; en10 = 1'b1;
      tick;
      tick;
      chk10("to9", 4'd9, 1'b0, 1'b0, 1'b1);
      clr10 = 1'b1;
      tick;
      chk10("race", 4'd0, 1'b1, 1'b1, 1'b0);
      clr10 = 1'b0;

      // direction change mid-count
      ld10 = 1'b1; din10 = 4'd5; en10 = 1'b0;
      tick;
      ld10 = 1'b0; en10 = 1'b1; up10 = 1'b0;
      tick;
      chk10("dirchg", 4'd4, 1'b0, 1'b1, 1'b0);

      // reset beats load/en/clr on the same edge
      ld10 = 1'b1; din10 = 4'd6; en10 = 1'b0;
      tick;
      chk("ld6.q", 32'(q10), 32'd6);
      en10 = 1'b1; up10 = 1'b1; din10 = 4'd3; clr10 = 1'b1; rst = 1'b1;
      tick;
      en10 = 1'b0; ld10 = 1'b0; clr10 = 1'b0;
      chk10("rstmid", 4'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick;
      chk10("rstpost", 4'd0, 1'b0, 1'b0, 1'b0);

      // full-range 4-bit wrap
      ld16 = 1'b1; din16 = 4'd14;
      tick;
      ld16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
      tick;
      chk("m16.q15", 32'(q16), 32'd15);
      chk("m16.tc", 32'(tc16), 32'd1);
      tick;
      chk("m16.q0", 32'(q16), 32'd0);
      chk("m16.wrap", 32'(wr16), 32'd1);
      chk("m16.ovf", 32'(ovf16), 32'd1);
      en16 = 1'b0;

      // 1-bit T flip-flop
      en2 = 1'b1; up2 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick;
         chk($sformatf("t1.q%0d", k), 32'(q2), 32'(k % 2));
         chk($sformatf("t1.qb%0d", k), 32'(qb2), 32'((k + 1) % 2));
         chk($sformatf("t1.w%0d", k), 32'(wr2), 32'(k % 2 == 0));
      end
      up2 = 1'b0;
      tick;
      chk("t1.dn.q", 32'(q2), 32'd1);
      chk("t1.dn.w", 32'(wr2), 32'd1);
      up2 = 1'b1;
      tick;
      chk("t1.up.q", 32'(q2), 32'd0);
      chk("t1.up.w", 32'(wr2), 32'd1);
      chk("t1.ovf", 32'(ovf2), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
